// File: rtl/threshold_line_buffer_if.sv
// Pixel stream in, classified 3-row column out, for the threshold line buffer.
// The master side drives pixels; the slave side (the buffer) returns columns.
interface threshold_line_buffer_if;
   logic       in_valid;
   logic       in_sof;
   logic [7:0] in_data;
   logic [2:0] R0;
   logic [2:0] R1;
   logic [2:0] R2;
   logic       out_valid;
   logic       out_eol;

   modport master (
      output in_valid, in_sof, in_data,
      input  R0, R1, R2, out_valid, out_eol
   );

   modport slave (
      input  in_valid, in_sof, in_data,
      output R0, R1, R2, out_valid, out_eol
   );
endinterface

// File: rtl/threshold_line_buffer.sv
// Double-threshold classifier feeding two line memories; emits one vertical
// 3-pixel column (rows y-2, y-1, y) per accepted pixel for hysteresis linking.
module threshold_line_buffer #(
   parameter int         IMG_WIDTH = 640,
   parameter logic [7:0] HIGH_TH   = 8'd100,
   parameter logic [7:0] LOW_TH    = 8'd40
) (
   input logic                   clk,
   input logic                   rst_n,
   threshold_line_buffer_if.slave bus
);

   localparam int            CW       = $clog2(IMG_WIDTH);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

   logic [2:0] lb_a [IMG_WIDTH];
   logic [2:0] lb_b [IMG_WIDTH];

   logic [CW-1:0] col_q, col_d, col_eff;
   logic [1:0]    row_cnt_q, row_cnt_d, row_eff;
   logic [2:0]    r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
   logic          out_valid_q, out_valid_d;
   logic          out_eol_q, out_eol_d;
   logic [2:0]    code;
   logic [2:0]    lb_a_rd, lb_b_rd;

   always_comb begin
      code = 3'b000;
      if (bus.in_data >= HIGH_TH) begin
         code = 3'b100;
      end else if (bus.in_data >= LOW_TH) begin
         code = 3'b010;
      end
   end

   // Start of frame overrides whatever position the counters had reached.
   assign col_eff = bus.in_sof ? '0 : col_q;
   assign row_eff = bus.in_sof ? 2'd0 : row_cnt_q;

   assign lb_a_rd = lb_a[col_eff];
   assign lb_b_rd = lb_b[col_eff];

   always_comb begin
      col_d       = col_q;
      row_cnt_d   = row_cnt_q;
      r0_d        = r0_q;
      r1_d        = r1_q;
      r2_d        = r2_q;
      out_eol_d   = out_eol_q;
      out_valid_d = 1'b0;
      if (bus.in_valid) begin
         r2_d        = code;
         r1_d        = lb_a_rd;
         r0_d        = lb_b_rd;
         out_valid_d = (row_eff == 2'd2);
         out_eol_d   = (col_eff == LAST_COL);
         if (col_eff == LAST_COL) begin
            col_d     = '0;
            row_cnt_d = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
         end else begin
            col_d     = col_eff + CW'(1);
            row_cnt_d = row_eff;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_cnt_q   <= 2'd0;
         r0_q        <= 3'b000;
         r1_q        <= 3'b000;
         r2_q        <= 3'b000;
         out_valid_q <= 1'b0;
         out_eol_q   <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_cnt_q   <= row_cnt_d;
         r0_q        <= r0_d;
         r1_q        <= r1_d;
         r2_q        <= r2_d;
         out_valid_q <= out_valid_d;
         out_eol_q   <= out_eol_d;
      end
   end

   // Line memories are left unreset so they map onto RAM; stale rows are
   // masked by out_valid until two fresh lines have been written.
   always_ff @(posedge clk) begin
      if (bus.in_valid) begin
         lb_a[col_eff] <= code;
         lb_b[col_eff] <= lb_a_rd;
      end
   end

   assign bus.R0        = r0_q;
   assign bus.R1        = r1_q;
   assign bus.R2        = r2_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_eol   = out_eol_q;

endmodule

// File: tb/tb_threshold_line_buffer.sv
// Self-checking bench: directed and randomized pixel streams checked against a
// frame-history model that looks rows up by absolute pixel index.
module tb_threshold_line_buffer;

   localparam int W = 4;

   logic clk;
   logic rst_n;

   threshold_line_buffer_if iv ();
   threshold_line_buffer_if iv2 ();

   threshold_line_buffer #(.IMG_WIDTH(W), .HIGH_TH(8'd100), .LOW_TH(8'd40)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (iv)
   );

   threshold_line_buffer #(.IMG_WIDTH(W), .HIGH_TH(8'd80), .LOW_TH(8'd80)) dut_eq (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (iv2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int vcount = 0;

   // Model state: every code of the current frame in arrival order.
   bit [2:0] hist[$];
   int       m_col = 0;
   int       m_row = 0;
   bit [2:0] exp_r0 = 3'b000, exp_r1 = 3'b000, exp_r2 = 3'b000;
   bit       exp_eol = 1'b0;
   bit       known01 = 1'b1;

   function automatic bit [2:0] classify(input int pix, input int hi, input int lo);
      if (pix >= hi) return 3'b100;
      if (pix >= lo) return 3'b010;
      return 3'b000;
   endfunction

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   task automatic check_output(input string tag, input bit exp_valid);
      if (iv.out_valid === 1'b1) vcount++;
      check({tag, ".valid"}, {7'd0, iv.out_valid}, {7'd0, exp_valid});
      check({tag, ".R2"}, {5'd0, iv.R2}, {5'd0, exp_r2});
      check({tag, ".eol"}, {7'd0, iv.out_eol}, {7'd0, exp_eol});
      if (known01) begin
         check({tag, ".R1"}, {5'd0, iv.R1}, {5'd0, exp_r1});
         check({tag, ".R0"}, {5'd0, iv.R0}, {5'd0, exp_r0});
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_col   = 0;
      m_row   = 0;
      exp_r0  = 3'b000;
      exp_r1  = 3'b000;
      exp_r2  = 3'b000;
      exp_eol = 1'b0;
      known01 = 1'b1;
   endtask

   task automatic apply_stimulus(input string tag, input bit sof, input logic [7:0] data);
      int  n;
      bit  exp_valid;
      iv.in_valid = 1'b1;
      iv.in_sof   = sof;
      iv.in_data  = data;
      if (sof) begin
         hist.delete();
         m_col = 0;
         m_row = 0;
      end
      n         = m_row * W + m_col;
      exp_valid = (m_row >= 2);
      exp_r2    = classify(int'(data), 100, 40);
      exp_eol   = (m_col == W - 1);
      known01   = exp_valid;
      if (exp_valid) begin
         exp_r1 = hist[n - W];
         exp_r0 = hist[n - 2 * W];
      end
      hist.push_back(exp_r2);
      m_col++;
      if (m_col == W) begin
         m_col = 0;
         m_row++;
      end
      @(posedge clk);
      #1;
      iv.in_valid = 1'b0;
      iv.in_sof   = 1'b0;
      check_output(tag, exp_valid);
   endtask

   task automatic idle_cycle(input string tag);
      iv.in_valid = 1'b0;
      iv.in_sof   = 1'b0;
      @(posedge clk);
      #1;
      check_output(tag, 1'b0);
   endtask

   task automatic send_rows(input string tag, input int r0v, input int r1v, input int r2v, input bit gapped);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < W; c++) begin
            logic [7:0] v;
            v = (r == 0) ? r0v[7:0] : (r == 1) ? r1v[7:0] : r2v[7:0];
            apply_stimulus(tag, (r == 0 && c == 0), v);
            if (gapped) idle_cycle({tag, ".gap"});
         end
      end
   endtask

   initial begin
      logic [7:0] cls_pat [4];
      logic [7:0] eq_pat [6];
      cls_pat = '{8'd99, 8'd100, 8'd39, 8'd40};
      eq_pat  = '{8'd79, 8'd80, 8'd81, 8'd200, 8'd0, 8'd100};

      rst_n        = 1'b0;
      iv.in_valid  = 1'b0;
      iv.in_sof    = 1'b0;
      iv.in_data   = 8'd0;
      iv2.in_valid = 1'b0;
      iv2.in_sof   = 1'b0;
      iv2.in_data  = 8'd0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_output("reset", 1'b0);
      rst_n = 1'b1;

      $display("[TB] classification");
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < W; c++)
            apply_stimulus("classify", (r == 0 && c == 0), cls_pat[c]);

      $display("[TB] row ordering");
      vcount = 0;
      send_rows("order", 200, 50, 0, 1'b0);
      check("order.vcount", 8'(vcount), 8'd4);

      $display("[TB] gapped input");
      vcount = 0;
      send_rows("gapped", 200, 50, 0, 1'b1);
      check("gapped.vcount", 8'(vcount), 8'd4);

      $display("[TB] resync");
      for (int i = 0; i < 6; i++) apply_stimulus("resync.old", (i == 0), 8'd255);
      send_rows("resync.new", 0, 0, 0, 1'b0);

      $display("[TB] randomized frames");
      for (int f = 0; f < 3; f++) begin
         for (int p = 0; p < 5 * W; p++) begin
            logic [7:0] v;
            case ($urandom_range(0, 5))
               0: v = 8'd39;
               1: v = 8'd40;
               2: v = 8'd99;
               3: v = 8'd100;
               default: v = 8'($urandom_range(0, 255));
            endcase
            apply_stimulus("random", (p == 0 && f != 1), v);
            if ($urandom_range(0, 3) == 0) idle_cycle("random.gap");
         end
      end

      $display("[TB] asynchronous reset mid-row 2");
      send_rows("prereset", 150, 60, 10, 1'b0);
      for (int c = 0; c < 2; c++) apply_stimulus("prereset.extra", 1'b0, 8'd120);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_output("async_reset", 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int p = 0; p < 2 * W + 2; p++) apply_stimulus("postreset", 1'b0, 8'(30 * p));

      $display("[TB] equal thresholds");
      for (int i = 0; i < 6 + 20; i++) begin
         logic [7:0] v;
         v = (i < 6) ? eq_pat[i] : 8'($urandom_range(60, 100));
         iv2.in_valid = 1'b1;
         iv2.in_data  = v;
         iv2.in_sof   = (i == 0);
         @(posedge clk);
         #1;
         iv2.in_valid = 1'b0;
         iv2.in_sof   = 1'b0;
         check("equal_th.R2", {5'd0, iv2.R2}, {5'd0, classify(int'(v), 80, 80)});
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/threshold_line_buffer.md
# threshold_line_buffer

Double-threshold classifier and two-line buffer that sits directly upstream of the hysteresis edge-linking stage in the Canny pipeline. It takes the non-maximum-suppressed 8-bit gradient magnitude stream and classifies each pixel as strong, weak or none. It then emits one 3-pixel vertical column per accepted pixel, oldest row on R0 and current row on R2, so the linking stage can build its 3x3 window from its own column shift register.

## Interface
- IMG_WIDTH, 640, pixels per line (OV7670 VGA); legal range 3..2048
- HIGH_TH, 8'd100, strong threshold; a pixel is strong if pix >= HIGH_TH
- LOW_TH, 8'd40, weak threshold; a pixel is weak if LOW_TH <= pix < HIGH_TH; LOW_TH <= HIGH_TH required
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data carries a pixel this cycle
- in_sof  in  1  qualified by in_valid; marks the first pixel of a frame
- in_data  in  8  NMS gradient magnitude
- R0  out  3  class code, row y-2, same column
- R1  out  3  class code, row y-1, same column
- R2  out  3  class code, row y (current pixel)
- out_valid  out  1  R0..R2 hold a new, fully populated column
- out_eol  out  1  qualified by out_valid; column is the last of its line

## Operation
- Class code: bit2 = strong, bit1 = weak, bit0 = 0. The only legal values are 3'b100, 3'b010 and 3'b000. If LOW_TH == HIGH_TH, no pixel is weak.
- State:
  - col counter, 0..IMG_WIDTH-1, width clog2(IMG_WIDTH)
  - row_cnt, saturating at 2
  - two line memories, lb_a and lb_b, each IMG_WIDTH x 3 bits. lb_a holds row y-1 and lb_b holds row y-2.
- On an accepted pixel (in_valid = 1):
  - Compute code from in_data.
  - Register R2 <= code, R1 <= lb_a[col], R0 <= lb_b[col].
  - Write lb_a[col] <= code and lb_b[col] <= lb_a[col] (read-before-write, same column).
  - out_valid <= (row_cnt == 2). out_eol <= (col == IMG_WIDTH-1).
  - If col == IMG_WIDTH-1: col <= 0, and row_cnt increments (saturating at 2). Otherwise col increments.
- in_sof with in_valid:
  - The pixel is treated as col 0, row 0. The current col value is ignored; sof wins over any col position.
  - Next state is col <= 1, row_cnt <= 0.
  - Line memories are not cleared. Stale data is masked because out_valid stays low for rows 0 and 1.
- No accepted pixel (in_valid = 0):
  - R0..R2 and out_eol hold their values; out_valid <= 0.
  - Counters and memories are unchanged.
- Line length mismatch: there is no line-end input. Lines are defined purely by counting IMG_WIDTH accepted pixels, and a short frame is resynchronised only by the next in_sof.
- Memories are single-write, single-read per cycle and must map to distributed or block RAM. Reset does not clear them.

## Timing
- Latency: exactly 1 cycle from an accepted pixel to R0..R2 / out_valid.
- Throughput: 1 pixel per clock sustained; arbitrary in_valid gaps are allowed.
- Downstream must advance its window only when out_valid = 1. R0..R2 are stable otherwise.
- Reset (rst = 0, asynchronous): R0 = R1 = R2 = 3'b000, out_valid = 0, out_eol = 0, col = 0, row_cnt = 0.
- Reset release: the first accepted pixel after release is col 0, row 0 even without in_sof.
- Reset mid-line: outputs clear immediately, and the partial frame is discarded.
- First valid output: the pixel at row 2, col 0, i.e. accepted pixel number 2*IMG_WIDTH+1 of a frame.

## Test plan
- Classification, IMG_WIDTH = 4, defaults. Stream rows 0..2 with in_data = 99, 100, 39, 40 in every row.
  - Rows 0 and 1: out_valid stays 0.
  - Row 2, each column: R2 = R1 = R0 = 010, 100, 000, 010 respectively.
  - out_eol = 1 only on column 3.
- Row ordering, IMG_WIDTH = 4. Row 0 all 200, row 1 all 50, row 2 all 0.
  - Row 2 outputs: R0 = 100, R1 = 010, R2 = 000 in every column.
  - out_valid = 1 exactly 4 times, each one cycle after its input.
- Gapped input: the same stream as the row-ordering case, with in_valid toggling 1,0,1,0.
  - Identical output sequence.
  - out_valid is never high in two consecutive cycles, and R0..R2 hold during gaps.
- Resync:
  - Send 6 pixels, then assert in_sof mid-line. out_valid stays 0 for the next 2*IMG_WIDTH accepted pixels.
  - The new row-2 columns contain only new-frame data: first-frame pixels 255, second frame 0, so outputs are 000.
- Reset:
  - Assert rst = 0 mid-row 2 (asynchronous, between clock edges). Outputs go to zero before the next clock edge.
  - After release, out_valid does not rise until 2*IMG_WIDTH+1 pixels have been accepted.
- Equal thresholds: LOW_TH = HIGH_TH = 80, inputs 79, 80, 81 give codes 000, 100, 100, and 010 never appears.
